// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared widths, special-value constants and record types for
//                the pipelined floating-point adder. The operand record is
//                sized for the widest supported format; instances use the
//                low-order bits that match their own EXP_W / MAN_W.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // Default format is binary32
    localparam int FP_EXP_W  = 8;
    localparam int FP_MAN_W  = 23;

    // Storage limits for width-independent records (covers binary64)
    localparam int MAX_EXP_W = 16;
    localparam int MAX_MAN_W = 63;
    localparam int MAX_SIG_W = MAX_MAN_W + 1;
    localparam int MAX_W     = MAX_EXP_W + MAX_MAN_W + 1;

    // Exponent bias for a given exponent field width
    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN {0, all-ones, 1, 0...} right-aligned in MAX_W bits
    function automatic logic [MAX_W-1:0] qnan_bits(input int exp_w, input int man_w);
        logic [MAX_W-1:0] one;
        one = MAX_W'(1);
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

    // Positive infinity {0, all-ones, 0...} right-aligned in MAX_W bits
    function automatic logic [MAX_W-1:0] inf_bits(input int exp_w, input int man_w);
        logic [MAX_W-1:0] one;
        one = MAX_W'(1);
        return ((one << exp_w) - one) << man_w;
    endfunction

    // Unpacked operand; sig includes the hidden bit, subnormals read as zero
    typedef struct packed {
        logic                 sign;
        logic [MAX_EXP_W-1:0] exp;
        logic [MAX_SIG_W-1:0] sig;
        logic                 is_zero;
        logic                 is_inf;
        logic                 is_nan;
    } fp_unpacked_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic inexact;
    } fp_flags_t;

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fp_lzc
//  Description : Parametrised leading-zero counter. An all-zero input
//                reports WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [CNT_W-1:0] o_count
);

    // Scan upward so the most significant set bit has the final say
    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fadd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fadd_pipe
//  Description : Three-stage IEEE-754 adder/subtractor with round-to-nearest-
//                even, flush-to-zero for subnormals, exception flags and a
//                globally stalled valid/ready handshake.
//                S1 unpack/swap/align, S2 add/normalise, S3 round/pack.
//  Revision    : 1.0 - initial release
// ============================================================================
module fadd_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_y,
    output logic                   out_invalid,
    output logic                   out_overflow,
    output logic                   out_inexact
);

    localparam int W     = EXP_W + MAN_W + 1;
    localparam int SIG_W = MAN_W + 1;
    localparam int ALN_W = MAN_W + 4;          // hidden + fraction + G/R/S
    localparam int LZC_W = $clog2(ALN_W + 1);

    localparam logic [W-1:0]     c_qnan      = W'(qnan_bits(EXP_W, MAN_W));
    localparam logic [W-2:0]     c_inf_mag   = (W-1)'(inf_bits(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] c_shift_max = EXP_W'(MAN_W + 3);
    localparam logic [EXP_W:0]   c_exp_max   = {1'b0, {EXP_W{1'b1}}};

    // ------------------------------------------------------------------
    // Handshake: one global stall for every stage
    // ------------------------------------------------------------------
    logic r_out_valid;
    logic w_advance;

    assign w_advance = ~r_out_valid | out_ready;
    assign in_ready  = w_advance;

    // ------------------------------------------------------------------
    // S1: unpack, classify, swap by magnitude, align smaller operand
    // ------------------------------------------------------------------
    function automatic fp_unpacked_t unpack_op(input logic [W-1:0] x, input logic flip);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        fp_unpacked_t     u;
        e         = x[W-2:MAN_W];
        f         = x[MAN_W-1:0];
        u         = '0;
        u.sign    = x[W-1] ^ flip;
        u.is_nan  = (&e) & (|f);
        u.is_inf  = (&e) & ~(|f);
        u.is_zero = ~(|e);
        if (|e) begin
            u.exp = MAX_EXP_W'(e);
            u.sig = MAX_SIG_W'({1'b1, f});
        end
        return u;
    endfunction

    fp_unpacked_t     w_ua, w_ub;
    logic [EXP_W-1:0] w_exp_a, w_exp_b, w_exp_big, w_exp_small, w_diff;
    logic [SIG_W-1:0] w_sig_a, w_sig_b, w_sig_big, w_sig_small;
    logic             w_a_big, w_sign_big, w_eff_sub;
    logic [ALN_W-1:0] w_small_ext, w_small_shift, w_small_aln;
    logic             w_small_lost;
    logic             w_any_nan, w_inf_clash, w_special;
    logic [W-1:0]     w_spec_y;

    // B's sign already carries the subtract request
    assign w_ua    = unpack_op(in_a, 1'b0);
    assign w_ub    = unpack_op(in_b, in_sub);
    assign w_exp_a = w_ua.exp[EXP_W-1:0];
    assign w_exp_b = w_ub.exp[EXP_W-1:0];
    assign w_sig_a = w_ua.sig[SIG_W-1:0];
    assign w_sig_b = w_ub.sig[SIG_W-1:0];

    assign w_a_big     = {w_exp_a, w_sig_a} >= {w_exp_b, w_sig_b};
    assign w_sign_big  = w_a_big ? w_ua.sign : w_ub.sign;
    assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
    assign w_exp_small = w_a_big ? w_exp_b : w_exp_a;
    assign w_sig_big   = w_a_big ? w_sig_a : w_sig_b;
    assign w_sig_small = w_a_big ? w_sig_b : w_sig_a;
    assign w_diff      = w_exp_big - w_exp_small;
    assign w_eff_sub   = w_ua.sign ^ w_ub.sign;

    // Right-align the smaller significand, folding shifted-out bits into sticky
    always_comb begin
        w_small_ext   = {w_sig_small, 3'b000};
        w_small_shift = w_small_ext >> w_diff;
        w_small_lost  = |(w_small_ext & ~({ALN_W{1'b1}} << w_diff));
        if (w_diff >= c_shift_max) begin
            w_small_aln = {{(ALN_W-1){1'b0}}, |w_sig_small};
        end else begin
            w_small_aln = w_small_shift | {{(ALN_W-1){1'b0}}, w_small_lost};
        end
    end

    assign w_any_nan   = w_ua.is_nan | w_ub.is_nan;
    assign w_inf_clash = w_ua.is_inf & w_ub.is_inf & (w_ua.sign ^ w_ub.sign);
    assign w_special   = w_any_nan | w_ua.is_inf | w_ub.is_inf;

    // Result for NaN/infinity operands, bypassing the arithmetic path
    always_comb begin
        if (w_any_nan || w_inf_clash) begin
            w_spec_y = c_qnan;
        end else if (w_ua.is_inf) begin
            w_spec_y = {w_ua.sign, c_inf_mag};
        end else begin
            w_spec_y = {w_ub.sign, c_inf_mag};
        end
    end

    logic             r1_valid, r1_special, r1_invalid, r1_sign, r1_eff_sub;
    logic [W-1:0]     r1_spec_y;
    logic [EXP_W-1:0] r1_exp;
    logic [ALN_W-1:0] r1_sig_big, r1_sig_small;

    // S1 data register, held while stalled
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r1_special   <= w_special;
            r1_invalid   <= w_any_nan | w_inf_clash;
            r1_spec_y    <= w_spec_y;
            r1_sign      <= w_sign_big;
            r1_eff_sub   <= w_eff_sub;
            r1_exp       <= w_exp_big;
            r1_sig_big   <= {w_sig_big, 3'b000};
            r1_sig_small <= w_small_aln;
        end
    end

    // ------------------------------------------------------------------
    // S2: add/subtract and normalise
    // ------------------------------------------------------------------
    logic [ALN_W:0]   w_sum;
    logic [LZC_W-1:0] w_lz;
    logic [ALN_W-1:0] w_norm_mant;
    logic [EXP_W:0]   w_norm_exp;
    logic             w_norm_zero, w_norm_uflow, w_norm_sign;

    assign w_sum = r1_eff_sub ? ({1'b0, r1_sig_big} - {1'b0, r1_sig_small})
                              : ({1'b0, r1_sig_big} + {1'b0, r1_sig_small});

    fp_lzc #(
        .WIDTH (ALN_W),
        .CNT_W (LZC_W)
    ) u_lzc (
        .i_vec   (w_sum[ALN_W-1:0]),
        .o_count (w_lz)
    );

    // Carry-out shifts right into sticky; otherwise shift left by the zero count
    always_comb begin
        w_norm_zero = ~(|w_sum);
        w_norm_sign = (w_norm_zero & r1_eff_sub) ? 1'b0 : r1_sign;
        if (w_sum[ALN_W]) begin
            w_norm_mant  = {w_sum[ALN_W:2], w_sum[1] | w_sum[0]};
            w_norm_exp   = {1'b0, r1_exp} + (EXP_W+1)'(1);
            w_norm_uflow = 1'b0;
        end else begin
            w_norm_mant  = w_sum[ALN_W-1:0] << w_lz;
            w_norm_exp   = {1'b0, r1_exp} - (EXP_W+1)'(w_lz);
            w_norm_uflow = {1'b0, r1_exp} <= (EXP_W+1)'(w_lz);
        end
    end

    logic             r2_valid, r2_special, r2_invalid, r2_sign, r2_zero, r2_uflow;
    logic [W-1:0]     r2_spec_y;
    logic [EXP_W:0]   r2_exp;
    logic [ALN_W-1:0] r2_mant;

    // S2 data register, held while stalled
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r2_special <= r1_special;
            r2_invalid <= r1_invalid;
            r2_spec_y  <= r1_spec_y;
            r2_sign    <= w_norm_sign;
            r2_zero    <= w_norm_zero;
            r2_uflow   <= w_norm_uflow;
            r2_exp     <= w_norm_exp;
            r2_mant    <= w_norm_mant;
        end
    end

    // ------------------------------------------------------------------
    // S3: round to nearest even, range check, pack
    // ------------------------------------------------------------------
    logic           w_round_up;
    logic [SIG_W:0] w_rounded;
    logic [EXP_W:0] w_exp_r;
    logic [W-1:0]   w_y;
    fp_flags_t      w_flags;

    // Mantissa carry from rounding leaves a zero fraction and bumps the exponent
    always_comb begin
        w_round_up      = r2_mant[2] & (r2_mant[1] | r2_mant[0] | r2_mant[3]);
        w_rounded       = {1'b0, r2_mant[ALN_W-1:3]} + (SIG_W+1)'(w_round_up);
        w_exp_r         = r2_exp + (EXP_W+1)'(w_rounded[SIG_W]);
        w_flags         = '0;
        w_flags.inexact = |r2_mant[2:0];
        w_y             = {r2_sign, w_exp_r[EXP_W-1:0], w_rounded[MAN_W-1:0]};
        if (r2_special) begin
            w_y             = r2_spec_y;
            w_flags         = '0;
            w_flags.invalid = r2_invalid;
        end else if (r2_zero) begin
            w_y     = {r2_sign, {(W-1){1'b0}}};
            w_flags = '0;
        end else if (r2_uflow) begin
            w_y             = {r2_sign, {(W-1){1'b0}}};
            w_flags.inexact = 1'b1;
        end else if (w_exp_r >= c_exp_max) begin
            w_y              = {r2_sign, c_inf_mag};
            w_flags.overflow = 1'b1;
            w_flags.inexact  = 1'b1;
        end
    end

    logic [W-1:0] r_out_y;
    fp_flags_t    r_out_flags;

    // Stage valids; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r2_valid    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_advance) begin
            r1_valid    <= in_valid;
            r2_valid    <= r1_valid;
            r_out_valid <= r2_valid;
        end
    end

    // Output register only changes when a real result moves in
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_y     <= '0;
            r_out_flags <= '0;
        end else if (w_advance && r2_valid) begin
            r_out_y     <= w_y;
            r_out_flags <= w_flags;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_y        = r_out_y;
    assign out_invalid  = r_out_flags.invalid;
    assign out_overflow = r_out_flags.overflow;
    assign out_inexact  = r_out_flags.inexact;

    // Record bits beyond this instance's format are intentionally ignored
    logic w_unused_bits;
    assign w_unused_bits = ^{w_ua.exp[MAX_EXP_W-1:EXP_W], w_ua.sig[MAX_SIG_W-1:SIG_W], w_ua.is_zero,
                             w_ub.exp[MAX_EXP_W-1:EXP_W], w_ub.sig[MAX_SIG_W-1:SIG_W], w_ub.is_zero,
                             w_rounded[MAN_W]};

endmodule
`default_nettype wire

// File: tb/tb_fadd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fadd_pipe
//  Description : Directed self-checking bench for fadd_pipe (binary32 and
//                binary64 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fadd_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, in_sub, out_valid, out_ready;
    logic        out_invalid, out_overflow, out_inexact;
    logic [31:0] in_a, in_b, out_y;

    logic        in_valid64, in_ready64, in_sub64, out_valid64, out_ready64;
    logic        out_invalid64, out_overflow64, out_inexact64;
    logic [63:0] in_a64, in_b64, out_y64;

    fadd_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_invalid  (out_invalid),
        .out_overflow (out_overflow),
        .out_inexact  (out_inexact)
    );

    fadd_pipe #(
        .EXP_W (11),
        .MAN_W (52)
    ) dut64 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid64),
        .in_ready     (in_ready64),
        .in_a         (in_a64),
        .in_b         (in_b64),
        .in_sub       (in_sub64),
        .out_valid    (out_valid64),
        .out_ready    (out_ready64),
        .out_y        (out_y64),
        .out_invalid  (out_invalid64),
        .out_overflow (out_overflow64),
        .out_inexact  (out_inexact64)
    );

    int errors = 0;
    int checks = 0;
    int idx, got, cyc, stale;
    logic take;

    logic [31:0] bp_b [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    logic [31:0] bp_y [5] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One isolated binary32 operation: latency, result and flags {inv,ovf,inx}
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_y, input logic [2:0] exp_f);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/lat"}, 64'(lat), 64'd3);
        chk(tag, {32'h0, out_y}, {32'h0, exp_y});
        chk({tag, "/flags"}, {61'h0, out_invalid, out_overflow, out_inexact}, {61'h0, exp_f});
    endtask

    task automatic run_op64(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic sub, input logic [63:0] exp_y);
        int lat;
        @(negedge clk);
        in_valid64 = 1'b1; in_a64 = a; in_b64 = b; in_sub64 = sub;
        @(posedge clk);
        @(negedge clk);
        in_valid64 = 1'b0;
        lat = 1;
        while (!out_valid64 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/lat"}, 64'(lat), 64'd3);
        chk(tag, out_y64, exp_y);
        chk({tag, "/flags"}, {61'h0, out_invalid64, out_overflow64, out_inexact64}, 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        in_valid64 = 1'b0; in_a64 = '0; in_b64 = '0; in_sub64 = 1'b0; out_ready64 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst/out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst/out_y", {32'h0, out_y}, 64'h0);
        chk("rst/flags", {61'h0, out_invalid, out_overflow, out_inexact}, 64'h0);
        chk("rst/in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst/out_valid64", {63'h0, out_valid64}, 64'h0);
        chk("rst/out_y64", out_y64, 64'h0);

        // Arithmetic and special values
        run_op("add_1p5_4p5",   32'h3FC00000, 32'h40900000, 1'b0, 32'h40C00000, 3'b000);
        run_op("sub_to_one",    32'h411AB852, 32'h410AB852, 1'b1, 32'h3F800000, 3'b000);
        run_op("cancel_pzero",  32'h410AB852, 32'hC10AB852, 1'b0, 32'h00000000, 3'b000);
        run_op("tie_even_down", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        run_op("tie_odd_up",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
        run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        run_op("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        run_op("nan_in",        32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        run_op("nzero_nzero",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        run_op("x_plus_zero",   32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 3'b000);
        run_op("ninf_plus_one", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
        run_op("subnorm_flush", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
        run_op("underflow",     32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
        run_op("neg_result",    32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);

        // Backpressure: five back-to-back ops with the consumer stalled
        @(negedge clk);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 5);
            in_a = 32'h3F800000;
            in_b = bp_b[(idx < 5) ? idx : 4];
            in_sub = 1'b0;
            #1;
            take = in_valid & in_ready;
            if (c == 5) chk("bp/hold_y_early", {32'h0, out_y}, {32'h0, bp_y[0]});
            @(posedge clk);
            if (take) idx++;
            @(negedge clk);
        end
        chk("bp/accepted", 64'(idx), 64'd3);
        chk("bp/in_ready_low", {63'h0, in_ready}, 64'h0);
        chk("bp/out_valid", {63'h0, out_valid}, 64'h1);
        chk("bp/hold_y_late", {32'h0, out_y}, {32'h0, bp_y[0]});

        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 40) begin
            in_valid = (idx < 5);
            in_b = bp_b[(idx < 5) ? idx : 4];
            #1;
            take = in_valid & in_ready;
            if (out_valid) begin
                chk($sformatf("bp/y%0d", got), {32'h0, out_y}, {32'h0, bp_y[got]});
                got++;
            end
            @(posedge clk);
            if (take) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp/result_count", 64'(got), 64'd5);

        // Reset with three operations in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_a = 32'h3F800000; in_b = bp_b[k]; in_sub = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_rst/in_flight", {63'h0, out_valid}, 64'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst/out_valid", {63'h0, out_valid}, 64'h0);
        chk("mid_rst/out_y", {32'h0, out_y}, 64'h0);
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            if (out_valid) stale++;
            @(negedge clk);
        end
        chk("mid_rst/stale", 64'(stale), 64'd0);
        chk("mid_rst/in_ready", {63'h0, in_ready}, 64'h1);

        // binary64 instance
        run_op64("d64_add", 64'h3FF8000000000000, 64'h4012000000000000, 1'b0, 64'h4018000000000000);
        run_op64("d64_sub", 64'h4000000000000000, 64'h3FF0000000000000, 1'b1, 64'h3FF0000000000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
Pipelined, parametrised IEEE-754 binary floating-point adder/subtractor. It is the clocked successor to the combinational single-precision adder.
- Adds generic exponent/mantissa widths, a per-operation add/sub mode and round-to-nearest-even.
- Handles special values and raises exception flags.
- Uses a valid/ready handshake with full backpressure.
- Sits between operand sources (register file/FIFO) and result consumers in the FP datapath.

Parameters:
EXP_W, 8, exponent field width (8 gives binary32, 11 gives binary64)
MAN_W, 23, stored fraction width (hidden bit excluded)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair present
in_ready  output  1  pipeline accepts operands this cycle
in_a  input  EXP_W+MAN_W+1  operand A {sign, exp, frac}
in_b  input  EXP_W+MAN_W+1  operand B
in_sub  input  1  1 computes A-B (B sign inverted), 0 computes A+B
out_valid  output  1  result present
out_ready  input  1  consumer takes result this cycle
out_y  output  EXP_W+MAN_W+1  rounded result
out_invalid  output  1  NaN generated (inf-inf, or any NaN input)
out_overflow  output  1  result rounded to infinity from finite inputs
out_inexact  output  1  guard/round/sticky nonzero

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. Every stage valid clears to 0. Outputs reset to out_valid=0, out_y=0, all flags 0. in_ready=1 on the first cycle after reset.
- Pipeline: 3 register stages, so latency is exactly 3 cycles from accept (in_valid&in_ready) to out_valid with no stall. Throughput is 1 per cycle.
  - S1: unpack, special-case detect, swap so |A|>=|B|, exponent difference, right-shift the smaller significand with guard/round/sticky. A shift of MAN_W+3 or more collapses everything into sticky.
  - S2: add or subtract significands (effective op = signA^signB^in_sub), then normalise. Carry-out shifts right 1 (OR the shifted bit into sticky). Otherwise a leading-zero count drives a left shift and exponent decrement.
  - S3: round-to-nearest-even on the guard/round/sticky bits. Mantissa overflow after rounding renormalises and increments the exponent. Check overflow, pack, set flags.
- Handshake: global stall. advance = !out_valid | out_ready. in_ready = advance. While advance is 0, all stages hold contents and out_y and flags stay stable. Order of results equals order of accepts.
- Simultaneous accept and emit in the same cycle is legal and loses no data.
- Subnormal inputs are flushed to signed zero. A result whose exponent underflows below 1 flushes to signed zero with out_inexact=1.
- Zeros: an exact cancellation yields +0. (-0)+(-0) yields -0. x+0 returns x exactly.
- Infinities: inf+finite gives that inf. inf+inf of the same sign gives inf. Opposite signs give canonical qNaN {0, all-ones, 1, 0...} with out_invalid=1.
- NaN input gives canonical qNaN with out_invalid=1.
- Overflow: the result exponent reaches all-ones, giving signed inf with out_overflow=1 and out_inexact=1.
- rst asserted mid-operation drops all in-flight operations at the next edge. There is no partial output.

Decomposition:
- Package fp_pkg holds:
  - localparams for field widths and the exponent bias (2^(EXP_W-1)-1);
  - the canonical qNaN and inf constants as functions of the widths;
  - an unpacked-operand struct {sign, exp, sig_with_hidden, is_zero, is_inf, is_nan};
  - a flags struct {invalid, overflow, inexact}.
- One sub-module: fp_lzc, a parametrised leading-zero counter (width MAN_W+4) used in S2.

Test Plan:
1. 0x3FC00000 + 0x40900000, in_sub=0 -> 0x40C00000 (6.0) exactly 3 cycles after accept, flags 0.
2. 0x411AB852 with 0x410AB852, in_sub=1 -> 0x3F800000 (1.0). Same operands negated-added, 0x410AB852 + 0xC10AB852 -> 0x00000000 (+0).
3. Tie rounding: 0x3F800000 + 0x33800000 -> 0x3F800000, inexact=1. 0x3F800001 + 0x33800000 -> 0x3F800002, inexact=1.
4. Specials: 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1. 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1.
5. Backpressure: issue 5 back-to-back ops with out_ready=0. Exactly 3 are accepted and in_ready stays low until out_ready=1. All 5 results emerge in order with out_y held stable during the stall.
6. Assert rst for one cycle with 3 ops in flight -> out_valid=0 next cycle and no stale result ever appears. Parameterise EXP_W=11, MAN_W=52: 0x3FF8000000000000 + 0x4012000000000000 -> 0x4018000000000000.
